// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state encoding, default word width and wait-counter width.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage, synchronous write and registered read, no reset.
// Ports: clk, we/addr/wdata (write), re (read strobe), rdata (read register).
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a request/response handshake and
// WAIT_CYCLES programmable wait states between accept and response.
// Ports: clk, rst (async, active-high); request side req_valid/req_ready/
// req_write/req_addr/req_wdata; response side resp_valid/resp_ready/
// resp_write/resp_rdata; busy flags WAIT or RESP.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              accept;
    logic              enter_resp;
    logic              op_write;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign busy       = (state == WAIT) || (state == RESP);

    // With zero wait states the access happens on the accept edge itself,
    // before the capture registers hold the request, so use the live inputs.
    assign op_write = (state == IDLE) ? req_write : cap_write;
    assign op_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign op_wdata = (state == IDLE) ? req_wdata : cap_wdata;

    assign enter_resp = (state == IDLE && accept && WAIT_CYCLES == 0) ||
                        (state == WAIT && cnt == 4'd1);

    // The array read register has no reset; mask it until a load lands.
    assign resp_rdata = rd_valid ? arr_rdata : '0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_n   = WAIT_INIT;
                    state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = RESP;
            end
            RESP: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_write <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (enter_resp) begin
                resp_write <= op_write;
                if (!op_write) rd_valid <= 1'b1;
            end
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (enter_resp && op_write),
        .re    (enter_resp && !op_write),
        .addr  (op_addr),
        .wdata (op_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Drives a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        rv, rw, rr;
    logic [7:0]  ra;
    logic [15:0] wd;
    logic        rdy, rsv, rsw, bsy;
    logic [15:0] rd;

    logic        rv0, rw0, rr0;
    logic [7:0]  ra0;
    logic [15:0] wd0;
    logic        rdy0, rsv0, rsw0, bsy0;
    logic [15:0] rd0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(rv), .req_ready(rdy), .req_write(rw),
        .req_addr(ra), .req_wdata(wd),
        .resp_valid(rsv), .resp_ready(rr), .resp_write(rsw),
        .resp_rdata(rd), .busy(bsy)
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_ready(rdy0), .req_write(rw0),
        .req_addr(ra0), .req_wdata(wd0),
        .resp_valid(rsv0), .resp_ready(rr0), .resp_write(rsw0),
        .resp_rdata(rd0), .busy(bsy0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one edge (the accept edge), then scramble inputs.
    task automatic req2(input logic w, input logic [7:0] a,
                        input logic [15:0] d);
        rv = 1'b1; rw = w; ra = a; wd = d;
        tick();
        rv = 1'b0; rw = ~w; ra = ~a; wd = ~d;
    endtask

    task automatic hs2;
        rr = 1'b1;
        tick();
        rr = 1'b0;
    endtask

    // Zero-wait transaction: response is up right after the accept edge.
    task automatic txn0(input string tag, input logic w, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd);
        rv0 = 1'b1; rw0 = w; ra0 = a; wd0 = d;
        tick();
        rv0 = 1'b0; ra0 = ~a; wd0 = ~d;
        chk({tag, "_valid"}, 16'(rsv0), 16'd1);
        chk({tag, "_write"}, 16'(rsw0), 16'(w));
        if (!w) chk({tag, "_rdata"}, rd0, exp_rd);
        rr0 = 1'b1;
        tick();
        rr0 = 1'b0;
        chk({tag, "_done"}, 16'(rsv0), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        rv = 0; rw = 0; rr = 0; ra = '0; wd = '0;
        rv0 = 0; rw0 = 0; rr0 = 0; ra0 = '0; wd0 = '0;
        tick();
        tick();
        chk("rst_resp_valid", 16'(rsv), 16'd0);
        chk("rst_resp_write", 16'(rsw), 16'd0);
        chk("rst_rdata", rd, 16'h0000);
        chk("rst_busy", 16'(bsy), 16'd0);
        chk("rst_ready_held", 16'(rdy), 16'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_rel", 16'(rdy), 16'd1);

        // store BEEF to 0x10, watch the wait states
        req2(1'b1, 8'h10, 16'hBEEF);
        chk("st_e1_ready", 16'(rdy), 16'd0);
        chk("st_e1_busy", 16'(bsy), 16'd1);
        chk("st_e1_valid", 16'(rsv), 16'd0);
        tick();
        chk("st_e2_valid", 16'(rsv), 16'd0);
        chk("st_e2_ready", 16'(rdy), 16'd0);
        tick();
        chk("st_e3_valid", 16'(rsv), 16'd1);
        chk("st_e3_write", 16'(rsw), 16'd1);
        chk("st_e3_ready", 16'(rdy), 16'd0);
        hs2();
        chk("st_hs_valid", 16'(rsv), 16'd0);
        chk("st_hs_ready", 16'(rdy), 16'd1);
        chk("st_hs_busy", 16'(bsy), 16'd0);

        // load it back
        req2(1'b0, 8'h10, 16'h0000);
        tick();
        chk("ld_e2_valid", 16'(rsv), 16'd0);
        tick();
        chk("ld_e3_valid", 16'(rsv), 16'd1);
        chk("ld_e3_write", 16'(rsw), 16'd0);
        chk("ld_e3_rdata", rd, 16'hBEEF);
        hs2();

        // backpressure with an ignored store pulse
        req2(1'b0, 8'h10, 16'h0000);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                rv = 1'b1; rw = 1'b1; ra = 8'h10; wd = 16'h0000;
            end
            if (i == 2) rv = 1'b0;
            tick();
            chk("bp_valid", 16'(rsv), 16'd1);
            chk("bp_rdata", rd, 16'hBEEF);
            chk("bp_ready", 16'(rdy), 16'd0);
        end
        rw = 1'b0;
        hs2();
        chk("bp_hs_ready", 16'(rdy), 16'd1);
        req2(1'b0, 8'h10, 16'h0000);
        tick();
        tick();
        chk("bp_ignored", rd, 16'hBEEF);
        hs2();

        // reset in the middle of a store
        req2(1'b1, 8'h20, 16'h5555);
        tick();
        tick();
        chk("rm_st_valid", 16'(rsv), 16'd1);
        hs2();
        req2(1'b1, 8'h20, 16'h1234);
        tick();
        chk("rm_wait_busy", 16'(bsy), 16'd1);
        rst = 1'b1;
        #1;
        chk("rm_valid", 16'(rsv), 16'd0);
        chk("rm_busy", 16'(bsy), 16'd0);
        chk("rm_write", 16'(rsw), 16'd0);
        chk("rm_rdata", rd, 16'h0000);
        chk("rm_ready", 16'(rdy), 16'd0);
        rst = 1'b0;
        #1;
        chk("rm_ready_rel", 16'(rdy), 16'd1);
        req2(1'b0, 8'h20, 16'h0000);
        tick();
        tick();
        chk("rm_ld_valid", 16'(rsv), 16'd1);
        chk("rm_ld_rdata", rd, 16'h5555);
        hs2();

        // response handshake with the next request already waiting
        req2(1'b0, 8'h10, 16'h0000);
        tick();
        tick();
        chk("ov_valid", 16'(rsv), 16'd1);
        rr = 1'b1;
        rv = 1'b1; rw = 1'b0; ra = 8'h20;
        tick();
        rr = 1'b0;
        chk("ov_hs_valid", 16'(rsv), 16'd0);
        chk("ov_hs_ready", 16'(rdy), 16'd1);
        chk("ov_hs_busy", 16'(bsy), 16'd0);
        tick();
        rv = 1'b0;
        chk("ov_acc_ready", 16'(rdy), 16'd0);
        chk("ov_acc_busy", 16'(bsy), 16'd1);
        tick();
        tick();
        chk("ov_ld_valid", 16'(rsv), 16'd1);
        chk("ov_ld_rdata", rd, 16'h5555);
        hs2();

        // zero wait states, both address extremes
        chk("z_idle_ready", 16'(rdy0), 16'd1);
        txn0("z_st00", 1'b1, 8'h00, 16'h1111, 16'h0000);
        txn0("z_stff", 1'b1, 8'hFF, 16'h2222, 16'h0000);
        txn0("z_ld00", 1'b0, 8'h00, 16'h0000, 16'h1111);
        txn0("z_ldff", 1'b0, 8'hFF, 16'h0000, 16'h2222);
        rr0 = 1'b1;
        tick();
        rr0 = 1'b0;
        chk("z_rr_idle", 16'(rdy0), 16'd1);
        txn0("z_ld00b", 1'b0, 8'h00, 16'h0000, 16'h1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
